// File: rtl/fifo_wr_arbiter.sv
// Write-side controller for the async FIFO: round-robin arbitration between a byte producer (A)
// and an atomic two-byte producer (B), with binary/Gray write pointer. Optional stall counter: FIFO_WR_ARB_STALL_CNT_EN.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   A_DATA,
    input  logic                    A_VLD,
    output logic                    A_RDY,
    input  logic [2*DATA_WIDTH-1:0] B_DATA,
    input  logic                    B_VLD,
    output logic                    B_RDY,
    input  logic                    FULL,
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    input  logic                    STALL_CLR,
    output logic [7:0]              STALL_CNT,
`endif
    output logic [DATA_WIDTH-1:0]   WR_DATA,
    output logic                    W_CLKEN,
    output logic [ADDR_WIDTH-1:0]   W_ADDR,
    output logic [ADDR_WIDTH:0]     W_PTR,
    output logic                    BUSY
);

    typedef enum logic {IDLE, B_HI} state_t;

    state_t              state;
    logic                last_grant_b;
    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] wr_ptr_nxt;
    logic                grant_a;
    logic                grant_b_lo;
    logic                grant_b_hi;

    function automatic logic [ADDR_WIDTH:0] bin2gray(input logic [ADDR_WIDTH:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign wr_ptr_nxt = wr_ptr + 1'b1;
    assign W_ADDR     = wr_ptr[ADDR_WIDTH-1:0];
    assign BUSY       = (state == B_HI);

    // Arbitration and write port: zero latency, the write lands on the handshake edge
    always_comb begin
        grant_a    = 1'b0;
        grant_b_lo = 1'b0;
        grant_b_hi = 1'b0;
        if (!RST && !FULL) begin
            if (state == B_HI)
                grant_b_hi = 1'b1;
            else if (A_VLD && (!B_VLD || last_grant_b))
                grant_a = 1'b1;
            else if (B_VLD)
                grant_b_lo = 1'b1;
        end
    end

    always_comb begin
        WR_DATA = '0;
        if (grant_a)
            WR_DATA = A_DATA;
        else if (grant_b_lo)
            WR_DATA = B_DATA[DATA_WIDTH-1:0];
        else if (grant_b_hi)
            WR_DATA = B_DATA[2*DATA_WIDTH-1:DATA_WIDTH];
    end

    assign W_CLKEN = grant_a | grant_b_lo | grant_b_hi;
    assign A_RDY   = grant_a;
    assign B_RDY   = grant_b_hi;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            last_grant_b <= 1'b1;
            wr_ptr       <= '0;
            W_PTR        <= '0;
        end else begin
            if (W_CLKEN) begin
                wr_ptr <= wr_ptr_nxt;
                W_PTR  <= bin2gray(wr_ptr_nxt);
            end
            if (grant_a)
                last_grant_b <= 1'b0;
            else if (grant_b_hi)
                last_grant_b <= 1'b1;
            if (grant_b_lo)
                state <= B_HI;
            else if (grant_b_hi)
                state <= IDLE;
        end
    end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
    // Counts cycles where a producer is held off by FULL; clear beats increment
    always_ff @(posedge CLK) begin
        if (RST || STALL_CLR)
            STALL_CNT <= 8'd0;
        else if (FULL && (A_VLD || B_VLD || state == B_HI))
            STALL_CNT <= sat_inc(STALL_CNT);
    end
`endif

endmodule
